// File: rtl/pipe_arith_hs_if.sv
// rtl/pipe_arith_hs_if.sv - operand/result handshake bundle for pipe_arith_hs
interface pipe_arith_hs_if #(
   parameter int N = 10
);
   logic                in_valid;
   logic                in_ready;
   logic signed [N-1:0] A;
   logic signed [N-1:0] B;
   logic signed [N-1:0] C;
   logic signed [N-1:0] D;
   logic                mode;
   logic                out_valid;
   logic                out_ready;
   logic signed [N-1:0] F;
   logic                ovf;

   modport master (
      output in_valid, A, B, C, D, mode, out_ready,
      input  in_ready, out_valid, F, ovf
   );

   modport slave (
      input  in_valid, A, B, C, D, mode, out_ready,
      output in_ready, out_valid, F, ovf
   );
endinterface

// File: rtl/pipe_arith_hs.sv
// rtl/pipe_arith_hs.sv - three-stage handshaked F = ((A+B) +/- (C-D)) * D
// PIPE_ARITH_SAT_EN selects saturating F instead of two's-complement wrap.
module pipe_arith_hs #(
   parameter int N = 10
) (
   input logic            clk,
   input logic            rst,
   pipe_arith_hs_if.slave bus
);
   localparam int PW = 2 * N + 2;

   logic signed [N:0]    x1_q, x1_d, x2_q, x2_d;
   logic signed [N-1:0]  d1_q, d1_d, d2_q, d2_d;
   logic                 m1_q, m1_d;
   logic signed [N+1:0]  x3_q, x3_d;
   logic signed [N-1:0]  f_q, f_d;
   logic                 ovf_q, ovf_d;
   logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic                 r1, r2, r3;
   logic signed [PW-1:0] p;
   logic                 p_fits;

   always_comb begin
      r3 = !v3_q || bus.out_ready;
      r2 = !v2_q || r3;
      r1 = !v1_q || r2;

      x1_d  = x1_q;
      x2_d  = x2_q;
      d1_d  = d1_q;
      m1_d  = m1_q;
      v1_d  = v1_q;
      x3_d  = x3_q;
      d2_d  = d2_q;
      v2_d  = v2_q;
      f_d   = f_q;
      ovf_d = ovf_q;
      v3_d  = v3_q;

      // P fits in N signed bits only when bits [PW-1:N-1] are all copies of the sign.
      p      = PW'(x3_q) * PW'(d2_q);
      p_fits = (&p[PW-1:N-1]) || !(|p[PW-1:N-1]);

      if (r1) begin
         v1_d = bus.in_valid;
         if (bus.in_valid) begin
            x1_d = (N+1)'(bus.A) + (N+1)'(bus.B);
            x2_d = (N+1)'(bus.C) - (N+1)'(bus.D);
            d1_d = bus.D;
            m1_d = bus.mode;
         end
      end

      if (r2) begin
         v2_d = v1_q;
         if (v1_q) begin
            x3_d = m1_q ? ((N+2)'(x1_q) - (N+2)'(x2_q))
                        : ((N+2)'(x1_q) + (N+2)'(x2_q));
            d2_d = d1_q;
         end
      end

      if (r3) begin
         v3_d = v2_q;
         if (v2_q) begin
            ovf_d = !p_fits;
`ifdef PIPE_ARITH_SAT_EN
            if (p_fits) begin
               f_d = p[N-1:0];
            end else if (p[PW-1]) begin
               f_d = {1'b1, {(N-1){1'b0}}};
            end else begin
               f_d = {1'b0, {(N-1){1'b1}}};
            end
`else
            f_d = p[N-1:0];
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x1_q  <= '0;
         x2_q  <= '0;
         d1_q  <= '0;
         m1_q  <= 1'b0;
         v1_q  <= 1'b0;
         x3_q  <= '0;
         d2_q  <= '0;
         v2_q  <= 1'b0;
         f_q   <= '0;
         ovf_q <= 1'b0;
         v3_q  <= 1'b0;
      end else begin
         x1_q  <= x1_d;
         x2_q  <= x2_d;
         d1_q  <= d1_d;
         m1_q  <= m1_d;
         v1_q  <= v1_d;
         x3_q  <= x3_d;
         d2_q  <= d2_d;
         v2_q  <= v2_d;
         f_q   <= f_d;
         ovf_q <= ovf_d;
         v3_q  <= v3_d;
      end
   end

   assign bus.in_ready  = r1;
   assign bus.out_valid = v3_q;
   assign bus.F         = f_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_arith_hs.sv
// tb/tb_pipe_arith_hs.sv - directed self-checking bench for pipe_arith_hs (N=8)
module tb_pipe_arith_hs;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   rcv;
   int   sent;
   logic acc;
   logic held;
   logic saw_in_ready_low;
   logic signed [7:0] fh;
   logic [8:0] exp_q[$];
   logic [8:0] exp_v;

   logic signed [7:0] ta[6] = '{8'sd1, 8'sd5, -8'sd3, 8'sd10, 8'sd0, -8'sd8};
   logic signed [7:0] tb_[6] = '{8'sd2, -8'sd6, 8'sd2, 8'sd10, 8'sd1, 8'sd4};
   logic signed [7:0] tc[6] = '{8'sd3, 8'sd7, 8'sd9, -8'sd10, 8'sd2, 8'sd1};
   logic signed [7:0] td[6] = '{8'sd4, -8'sd1, 8'sd5, 8'sd3, -8'sd7, 8'sd6};
   logic              tm[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

   pipe_arith_hs_if #(.N(8)) bus ();

   pipe_arith_hs #(.N(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] model(input logic signed [7:0] a, input logic signed [7:0] b,
                                        input logic signed [7:0] c, input logic signed [7:0] d,
                                        input logic m);
      longint x1, x2, x3, p;
      logic   o;
      logic [7:0] f;
      x1 = longint'(a) + longint'(b);
      x2 = longint'(c) - longint'(d);
      x3 = m ? (x1 - x2) : (x1 + x2);
      p  = x3 * longint'(d);
      o  = (p > 127) || (p < -128);
`ifdef PIPE_ARITH_SAT_EN
      f = (p > 127) ? 8'h7F : (p < -128) ? 8'h80 : p[7:0];
`else
      f = p[7:0];
`endif
      return {o, f};
   endfunction

   // One clock: sample handshakes at the falling edge, then step past the rising edge.
   task automatic tick(output logic accepted);
      @(negedge clk);
      accepted = bus.in_valid && bus.in_ready;
      if (!bus.in_ready) saw_in_ready_low = 1'b1;
      if (accepted) exp_q.push_back(model(bus.A, bus.B, bus.C, bus.D, bus.mode));
      if (bus.out_valid && bus.out_ready) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_output observed F=%0h with no pending transaction", bus.F);
         end
         if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            rcv++;
            checks++;
            assert ({bus.ovf, bus.F} === exp_v) else begin
               errors++;
               $error("FAIL result observed ovf/F=%0h expected %0h", {bus.ovf, bus.F}, exp_v);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_one(input logic signed [7:0] a, input logic signed [7:0] b,
                           input logic signed [7:0] c, input logic signed [7:0] d,
                           input logic m, input logic [7:0] ef, input logic eo);
      logic a_ok;
      bus.A = a; bus.B = b; bus.C = c; bus.D = d; bus.mode = m;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      tick(a_ok);
      bus.in_valid = 1'b0;
      checks++;
      assert (bus.out_valid === 1'b0) else begin
         errors++; $error("FAIL latency_e0 observed out_valid=%b expected 0", bus.out_valid);
      end
      tick(a_ok);
      checks++;
      assert (bus.out_valid === 1'b0) else begin
         errors++; $error("FAIL latency_e1 observed out_valid=%b expected 0", bus.out_valid);
      end
      tick(a_ok);
      checks++;
      assert (bus.out_valid === 1'b1) else begin
         errors++; $error("FAIL latency_e2 observed out_valid=%b expected 1", bus.out_valid);
      end
      checks++;
      assert (bus.F === ef) else begin
         errors++; $error("FAIL directed_F observed %0h expected %0h", bus.F, ef);
      end
      checks++;
      assert (bus.ovf === eo) else begin
         errors++; $error("FAIL directed_ovf observed %b expected %b", bus.ovf, eo);
      end
      tick(a_ok);
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.A = '0; bus.B = '0; bus.C = '0; bus.D = '0; bus.mode = 1'b0;
      rcv = 0;
      saw_in_ready_low = 1'b0;
      tick(acc);
      tick(acc);
      rst = 1'b0;
      checks++;
      assert (bus.out_valid === 1'b0) else begin
         errors++; $error("FAIL reset_out_valid observed %b expected 0", bus.out_valid);
      end
      checks++;
      assert (bus.in_ready === 1'b1) else begin
         errors++; $error("FAIL reset_in_ready observed %b expected 1", bus.in_ready);
      end
      checks++;
      assert ({bus.ovf, bus.F} === 9'h000) else begin
         errors++; $error("FAIL reset_F_ovf observed %0h expected 0", {bus.ovf, bus.F});
      end

      send_one(8'sd3, 8'sd4, 8'sd10, 8'sd2, 1'b0, 8'd30, 1'b0);
      send_one(8'sd3, 8'sd4, 8'sd10, 8'sd2, 1'b1, 8'hFE, 1'b0);
`ifdef PIPE_ARITH_SAT_EN
      send_one(8'sd100, 8'sd100, 8'sd100, -8'sd100, 1'b0, 8'h80, 1'b1);
`else
      send_one(8'sd100, 8'sd100, 8'sd100, -8'sd100, 1'b0, 8'hC0, 1'b1);
`endif

      // Back-pressure: out_ready low for cycles 4..8 while six transactions stream in.
      rcv = 0;
      sent = 0;
      saw_in_ready_low = 1'b0;
      for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
         bus.in_valid = (sent < 6);
         if (sent < 6) begin
            bus.A = ta[sent]; bus.B = tb_[sent]; bus.C = tc[sent];
            bus.D = td[sent]; bus.mode = tm[sent];
         end
         bus.out_ready = !(cyc >= 4 && cyc < 9);
         held = bus.out_valid && !bus.out_ready;
         fh = bus.F;
         tick(acc);
         if (acc) sent++;
         if (held) begin
            checks++;
            assert (bus.out_valid === 1'b1 && bus.F === fh) else begin
               errors++;
               $error("FAIL stall_stable observed v=%b F=%0h expected v=1 F=%0h", bus.out_valid, bus.F, fh);
            end
         end
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      checks++;
      assert (saw_in_ready_low === 1'b1) else begin
         errors++; $error("FAIL bp_in_ready observed never low expected low during stall");
      end
      checks++;
      assert (rcv === 6) else begin
         errors++; $error("FAIL bp_count observed %0d expected 6", rcv);
      end

      // Full throughput with random operands.
      rcv = 0;
      for (int k = 0; k < 20; k++) begin
         bus.in_valid = 1'b1;
         bus.out_ready = 1'b1;
         bus.A = 8'($urandom); bus.B = 8'($urandom);
         bus.C = 8'($urandom); bus.D = 8'($urandom);
         bus.mode = 1'($urandom);
         tick(acc);
         if (k >= 2) begin
            checks++;
            assert (bus.out_valid === 1'b1) else begin
               errors++; $error("FAIL thru_valid k=%0d observed %b expected 1", k, bus.out_valid);
            end
         end
      end
      bus.in_valid = 1'b0;
      repeat (4) tick(acc);
      checks++;
      assert (rcv === 20) else begin
         errors++; $error("FAIL thru_count observed %0d expected 20", rcv);
      end

      // Reset on the cycle after two transfers discards both.
      bus.in_valid = 1'b1;
      bus.A = 8'sd7; bus.B = 8'sd1; bus.C = 8'sd2; bus.D = 8'sd3; bus.mode = 1'b0;
      tick(acc);
      bus.D = 8'sd5;
      tick(acc);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick(acc);
      exp_q.delete();
      checks++;
      assert (bus.out_valid === 1'b0 && bus.in_ready === 1'b1) else begin
         errors++; $error("FAIL midrst_hs observed v=%b r=%b expected v=0 r=1", bus.out_valid, bus.in_ready);
      end
      checks++;
      assert ({bus.ovf, bus.F} === 9'h000) else begin
         errors++; $error("FAIL midrst_F_ovf observed %0h expected 0", {bus.ovf, bus.F});
      end
      rst = 1'b0;
      rcv = 0;
      repeat (6) tick(acc);
      checks++;
      assert (rcv === 0 && bus.out_valid === 1'b0) else begin
         errors++; $error("FAIL midrst_ghost observed %0d results expected 0", rcv);
      end
      checks++;
      assert (exp_q.size() === 0) else begin
         errors++; $error("FAIL pending observed %0d left expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_arith_hs.md
# pipe_arith_hs

Parametrised, handshaked successor to the team's fixed three-stage arithmetic pipeline. It computes F = ((A + B) ± (C − D)) × D on N-bit signed operands. D is carried down the pipe alongside its own sample, so every result uses the operands of a single transaction. Per-stage valid/ready flow control gives one result per clock at full throughput, and the block sits between an operand producer and a result consumer that may stall.

## Interface
- N, default 10: operand and result width in bits, two's complement; legal range 4–32.
- clk  in  1  rising-edge clock for every register in the block.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  in  1  the operand set on A, B, C, D and mode is valid.
- in_ready  out  1  the block accepts the operands this cycle. Combinational from stage state and out_ready.
- A, B, C, D  in  N each  signed operands.
- mode  in  1  0: x3 = x1 + x2. 1: x3 = x1 − x2. Captured with the operands.
- out_valid  out  1  F and ovf hold a valid result.
- out_ready  in  1  the consumer takes the result this cycle.
- F  out  N  signed result.
- ovf  out  1  the full-precision product does not fit in N signed bits.

## Operation
- Stage 1 registers:
  - x1 = A + B, N+1 bits, sign-extended.
  - x2 = C − D, N+1 bits.
  - D, sign-extended.
  - mode.
  - v1.
- Stage 2 registers:
  - x3 = x1 ± x2, N+2 bits, operation selected by the stage-1 mode.
  - D.
  - v2.
- Stage 3 registers:
  - Full product P = x3 × D, 2N+2 bits.
  - F, reduced from P (see Configuration).
  - ovf = (P > 2^(N−1) − 1) or (P < −2^(N−1)).
  - v3.
- Flow control uses per-stage ready, so bubbles collapse:
  - r3 = !v3 || out_ready
  - r2 = !v2 || r3
  - r1 = !v1 || r2
  - in_ready = r1
- Stage k loads when rk is high:
  - Its valid bit takes the upstream valid.
  - Its data registers load only when the upstream valid is 1. Otherwise they hold.
- out_valid = v3.
- While out_valid && !out_ready:
  - F and ovf stay stable.
  - A full pipe deasserts in_ready in the same cycle.
- Transfers:
  - Input transfer = in_valid && in_ready at a rising edge.
  - Output transfer = out_valid && out_ready at a rising edge.
  - Both may occur on the same edge. With a full pipe and out_ready = 1, the pipe shifts and a new input is accepted on that edge.
- in_valid held with in_ready low: the operands are not consumed. The producer must hold them.
- Reset:
  - v1, v2 and v3 clear to 0, so out_valid = 0 and in_ready = 1 on the cycle after reset.
  - F, ovf and all data registers clear to 0.
  - Reset asserted mid-operation discards every in-flight transaction. No partial result is emitted.

## Timing
- Latency: an input transferred on edge E0 produces out_valid = 1 after edge E0+2, provided no stage stalls. That is three register stages.
- Throughput: one transaction per clock while out_ready stays high.
- Stall: each cycle of out_ready low adds one cycle of latency to every transaction still in flight.
- Order: results leave in acceptance order. None is dropped or duplicated.
- No combinational path from A, B, C or D to F. The only combinational path is out_ready → in_ready.

## Configuration
- PIPE_ARITH_SAT_EN defined:
  - F saturates to 2^(N−1) − 1 when P is above range.
  - F saturates to −2^(N−1) when P is below range.
- PIPE_ARITH_SAT_EN undefined: F = P[N−1:0], two's-complement wrap.
- ovf behaves identically in both builds.

## Test plan
- Basic (N=8, mode=0): A=3, B=4, C=10, D=2 → after 3 edges, out_valid=1, F=30, ovf=0.
- Subtract mode: same operands with mode=1 → x3 = 7 − 8 = −1, F = −2 (0xFE), ovf=0.
- Overflow: A=100, B=100, C=100, D=−100 → P = −40000, ovf=1. F = −128 (0x80) with PIPE_ARITH_SAT_EN, F = 0xC0 without.
- Back-pressure:
  - Stream 6 distinct transactions.
  - Hold out_ready=0 for 5 cycles from cycle 4.
  - Required: in_ready falls once three results are stalled, F stays stable during the stall, all 6 results arrive in order with the correct D pairing and none is lost.
- Full throughput: in_valid=1 and out_ready=1 for 20 cycles with random operands → a result every cycle from cycle 3 on, each matching the reference model.
- Reset mid-flight: reset on the cycle after two transfers → out_valid=0, F=0, ovf=0, in_ready=1 next cycle, and neither in-flight result ever appears.
